mem_req_ctrl: RTL and testbench

Parametrised single-port memory with a valid/ready request channel and a back-pressured response channel. It replaces the fixed 32x8 memory used by the memory-interface tests. The block adds:
- byte-enable writes
- configurable read latency
- automatic zero-fill after reset
- optional per-byte parity

Testbench tasks and higher-level masters drive it through the request channel only.

---
 rtl/mem_req_pkg.sv | 23 ++
 rtl/mem_req_array.sv | 78 +++++++
 rtl/mem_req_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared definitions for the mem_req_ctrl memory block.
//   - state_e      : controller FSM states
//   - RD_LAT_MAX   : largest supported read latency (RD_LAT range 1..RD_LAT_MAX)
//   - byte_parity  : even-parity bit of one byte lane
// Optional feature macro used by the files importing this package: MEM_PARITY_EN.
package mem_req_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int RD_LAT_MAX = 4;

    // Even parity: the stored bit makes the total count of ones in
    // {byte, parity} even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mem_req_array.sv
// Storage for mem_req_ctrl: DEPTH words of DATA_W bits with per-byte-lane
// write enables and a combinational (asynchronous) read port.
// With MEM_PARITY_EN defined, one even-parity bit per lane is stored next to
// the data and checked on the read port.
// Ports:
//   clk      in   clock
//   we       in   write strobe (qualified by be)
//   be       in   NB lane enables
//   waddr    in   write word address
//   wdata    in   write data
//   par_flip in   (MEM_PARITY_EN) invert stored parity of these lanes
//   rd_err   out  (MEM_PARITY_EN) parity mismatch on the word at raddr
//   raddr    in   read word address
//   rdata    out  word at raddr
module mem_req_array
    import mem_req_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [NB-1:0]     be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
`ifdef MEM_PARITY_EN
    input  logic [NB-1:0]     par_flip,
    output logic              rd_err,
`endif
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [NB-1:0]     lane_we;

    always_comb begin
        lane_we = be & {NB{we}};
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (lane_we[i]) begin
                mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem_q[raddr];

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] rpar;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (lane_we[i]) begin
                par_q[waddr][i] <= byte_parity(wdata[i*8 +: 8]) ^ par_flip[i];
            end
        end
    end

    assign rpar = par_q[raddr];

    always_comb begin
        rd_err = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (byte_parity(rdata[i*8 +: 8]) != rpar[i]) begin
                rd_err = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_req_ctrl.sv
// Single-port memory with a valid/ready request channel and a back-pressured
// response channel. After reset the array is zero-filled, one word per cycle,
// before any request is accepted. Writes use byte enables and produce no
// response; reads return data RD_LAT cycles after acceptance and hold it
// until rsp_ready.
// Optional feature: MEM_PARITY_EN adds per-lane parity and the err_inject port.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. The master
// holds req_* stable while req_valid && !req_ready; rsp_rdata/rsp_err are held
// stable while rsp_valid && !rsp_ready.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake
//   req_write         1 = write, 0 = read
//   req_addr          word address
//   req_wdata, req_be write data and lane enables (be ignored on reads)
//   rsp_valid/ready   response handshake
//   rsp_rdata         read data
//   rsp_err           parity error on this response (0 without MEM_PARITY_EN)
//   err_inject        (MEM_PARITY_EN) corrupt stored parity on a write
module mem_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1    // legal range 1..RD_LAT_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
`ifdef MEM_PARITY_EN
    input  logic                err_inject,
`endif
    output logic                rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LAT_W = $clog2(RD_LAT_MAX);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              arr_we;
    logic [NB-1:0]     arr_be;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic              arr_err;

`ifdef MEM_PARITY_EN
    logic [NB-1:0]     arr_flip;
`endif

    mem_req_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk     (clk),
        .we      (arr_we),
        .be      (arr_be),
        .waddr   (arr_waddr),
        .wdata   (arr_wdata),
`ifdef MEM_PARITY_EN
        .par_flip(arr_flip),
        .rd_err  (arr_err),
`endif
        .raddr   (rd_addr_q),
        .rdata   (arr_rdata)
    );

`ifndef MEM_PARITY_EN
    assign arr_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        lat_cnt_d   = lat_cnt_q;
        rd_addr_d   = rd_addr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        arr_we      = 1'b0;
        arr_be      = '0;
        arr_waddr   = req_addr;
        arr_wdata   = req_wdata;
`ifdef MEM_PARITY_EN
        arr_flip    = '0;
`endif
        req_ready   = (state_q == IDLE);
        rsp_valid   = (state_q == RESP);

        unique case (state_q)
            CLEAR: begin
                // Zero-fill walks the whole array; parity written alongside
                // is the correct (even) parity of zero.
                arr_we    = 1'b1;
                arr_be    = '1;
                arr_waddr = clr_ptr_q;
                arr_wdata = '0;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    if (req_write) begin
                        arr_we = 1'b1;
                        arr_be = req_be;
`ifdef MEM_PARITY_EN
                        arr_flip = req_be & {NB{err_inject}};
`endif
                    end else begin
                        state_d   = READ;
                        lat_cnt_d = LAT_INIT;
                        rd_addr_d = req_addr;
                    end
                end
            end
            READ: begin
                if (lat_cnt_q == '0) begin
                    rsp_rdata_d = arr_rdata;
                    rsp_err_d   = arr_err;
                    state_d     = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase

        // An array write on the same edge as reset is discarded: reset
        // always wins and the fill restarts from address 0.
        if (rst) begin
            arr_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_ptr_q   <= '0;
            lat_cnt_q   <= '0;
            rd_addr_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            lat_cnt_q   <= lat_cnt_d;
            rd_addr_q   <= rd_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl. Two instances share one request stream:
//   dut_n : defaults (ADDR_W=5, DATA_W=8, RD_LAT=1), sees wdata[7:0], be[0]
//   dut_w : DATA_W=32, RD_LAT=3
// Requests are only issued when both are ready, so both see identical
// transactions. Honors MEM_PARITY_EN when defined.
module tb_mem_req_ctrl;

`ifdef MEM_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b1;
    logic        err_inject = 1'b0;

    logic        rdy_n, rdy_w, vld_n, vld_w, err_n, err_w;
    logic [7:0]  rdata_n;
    logic [31:0] rdata_w;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_req_ctrl dut_n (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy_n), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata[7:0]), .req_be(req_be[0:0]),
        .rsp_valid(vld_n), .rsp_ready(rsp_ready), .rsp_rdata(rdata_n),
`ifdef MEM_PARITY_EN
        .err_inject(err_inject),
`endif
        .rsp_err(err_n)
    );

    mem_req_ctrl #(.ADDR_W(5), .DATA_W(32), .RD_LAT(3)) dut_w (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy_w), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld_w), .rsp_ready(rsp_ready), .rsp_rdata(rdata_w),
`ifdef MEM_PARITY_EN
        .err_inject(err_inject),
`endif
        .rsp_err(err_w)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        inj;
        logic [7:0]  exp_n;
        logic [31:0] exp_w;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!(rdy_n && rdy_w) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!(rdy_n && rdy_w)) chk("wait_ready timeout", {30'h0, rdy_n, rdy_w}, 32'h3);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic inj);
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_addr = a;
        req_wdata = d; req_be = be; err_inject = inj;
        @(posedge clk); #1;
        req_valid = 1'b0; err_inject = 1'b0;
    endtask

    // Issues a read and captures each instance's first response plus its
    // latency in cycles counted from the acceptance edge (-1 = never).
    task automatic do_read(input logic [4:0] a,
                           output logic [31:0] d_n, output logic [31:0] d_w,
                           output logic e_n, output logic e_w,
                           output int l_n, output int l_w);
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_be = 4'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        l_n = -1; l_w = -1; d_n = '0; d_w = '0; e_n = 1'b0; e_w = 1'b0;
        for (int k = 1; k <= 20 && (l_n < 0 || l_w < 0); k++) begin
            @(posedge clk); #1;
            if (vld_n && l_n < 0) begin l_n = k; d_n = {24'h0, rdata_n}; e_n = err_n; end
            if (vld_w && l_w < 0) begin l_w = k; d_w = rdata_w; e_w = err_w; end
        end
    endtask

    // Called with rst just lowered: counts edges until each instance is ready.
    task automatic count_fill(input string tag);
        int c_n, c_w;
        logic any_vld;
        c_n = -1; c_w = -1; any_vld = 1'b0;
        for (int k = 1; k <= 100 && (c_n < 0 || c_w < 0); k++) begin
            @(posedge clk); #1;
            if (vld_n || vld_w) any_vld = 1'b1;
            if (rdy_n && c_n < 0) c_n = k;
            if (rdy_w && c_w < 0) c_w = k;
        end
        chk({tag, " fill cycles n"}, 32'(c_n), 32'd32);
        chk({tag, " fill cycles w"}, 32'(c_w), 32'd32);
        chk({tag, " rsp_valid during fill"}, {31'h0, any_vld}, 32'h0);
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a,
                            input logic [7:0] exp_n, input logic [31:0] exp_w,
                            input logic exp_err);
        logic [31:0] d_n, d_w;
        logic e_n, e_w;
        int l_n, l_w;
        do_read(a, d_n, d_w, e_n, e_w, l_n, l_w);
        chk({tag, " rdata n"}, d_n, {24'h0, exp_n});
        chk({tag, " rdata w"}, d_w, exp_w);
        chk({tag, " lat n"}, 32'(l_n), 32'd1);
        chk({tag, " lat w"}, 32'(l_w), 32'd3);
        chk({tag, " err n"}, {31'h0, e_n}, {31'h0, exp_err});
        chk({tag, " err w"}, {31'h0, e_w}, {31'h0, exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'h000000A5, 4'hF, 1'b0, 8'h00, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 5'd5, 32'h0,        4'h0, 1'b0, 8'hA5, 32'h000000A5, 1'b0};
        vecs[2] = '{1'b1, 5'd2, 32'h11223344, 4'hF, 1'b0, 8'h00, 32'h0, 1'b0};
        vecs[3] = '{1'b1, 5'd2, 32'hAABBCCDD, 4'h5, 1'b0, 8'h00, 32'h0, 1'b0};
        vecs[4] = '{1'b0, 5'd2, 32'h0,        4'h0, 1'b0, 8'hDD, 32'h11BB33DD, 1'b0};
        vecs[5] = '{1'b1, 5'd9, 32'h0000003C, 4'hF, 1'b1, 8'h00, 32'h0, 1'b0};
        vecs[6] = '{1'b0, 5'd9, 32'h0,        4'h0, 1'b0, 8'h3C, 32'h0000003C, PAR_ON};
        vecs[7] = '{1'b1, 5'd9, 32'h0000003C, 4'hF, 1'b0, 8'h00, 32'h0, 1'b0};
        vecs[8] = '{1'b0, 5'd9, 32'h0,        4'h0, 1'b0, 8'h3C, 32'h0000003C, 1'b0};

        // Reset values, then zero-fill length.
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset req_ready n", {31'h0, rdy_n}, 32'h0);
        chk("reset req_ready w", {31'h0, rdy_w}, 32'h0);
        chk("reset rsp_valid n", {31'h0, vld_n}, 32'h0);
        chk("reset rsp_valid w", {31'h0, vld_w}, 32'h0);
        chk("reset rsp_rdata n", {24'h0, rdata_n}, 32'h0);
        chk("reset rsp_rdata w", rdata_w, 32'h0);
        chk("reset rsp_err n", {31'h0, err_n}, 32'h0);
        chk("reset rsp_err w", {31'h0, err_w}, 32'h0);
        rst = 1'b0;
        count_fill("por");

        read_chk("zero a0", 5'd0, 8'h00, 32'h0, 1'b0);
        read_chk("zero a17", 5'd17, 8'h00, 32'h0, 1'b0);
        read_chk("zero a31", 5'd31, 8'h00, 32'h0, 1'b0);

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].inj);
            end else begin
                read_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_n,
                         vecs[i].exp_w, vecs[i].exp_err);
            end
        end

        // Back-to-back writes, one per cycle, then read every address back.
        for (int a = 0; a < 32; a++) begin
            do_write(5'(a), 32'(a), 4'hF, 1'b0);
        end
        for (int a = 0; a < 32; a++) begin
            read_chk($sformatf("b2b a%0d", a), 5'(a), 8'(a), 32'(a), 1'b0);
        end

        // Backpressure: response held for 5 cycles with rsp_ready low.
        do_write(5'd7, 32'h0F1E2D3C, 4'hF, 1'b0);
        rsp_ready = 1'b0;
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 10 && !(vld_n && vld_w); k++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d rsp_valid n", k), {31'h0, vld_n}, 32'h1);
            chk($sformatf("bp%0d rsp_valid w", k), {31'h0, vld_w}, 32'h1);
            chk($sformatf("bp%0d rdata n", k), {24'h0, rdata_n}, 32'h3C);
            chk($sformatf("bp%0d rdata w", k), rdata_w, 32'h0F1E2D3C);
            chk($sformatf("bp%0d req_ready n", k), {31'h0, rdy_n}, 32'h0);
            chk($sformatf("bp%0d req_ready w", k), {31'h0, rdy_w}, 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release req_ready n", {31'h0, rdy_n}, 32'h1);
        chk("bp release req_ready w", {31'h0, rdy_w}, 32'h1);
        chk("bp release rsp_valid n", {31'h0, vld_n}, 32'h0);
        chk("bp release rsp_valid w", {31'h0, vld_w}, 32'h0);

        // Reset the cycle after a read is accepted.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrd rsp_valid n", {31'h0, vld_n}, 32'h0);
        chk("midrd rsp_valid w", {31'h0, vld_w}, 32'h0);
        chk("midrd req_ready n", {31'h0, rdy_n}, 32'h0);
        rst = 1'b0;
        count_fill("midrd");
        read_chk("refill a5", 5'd5, 8'h00, 32'h0, 1'b0);
        read_chk("refill a7", 5'd7, 8'h00, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
